dff_r: RTL and testbench

- Parameterizable D-type register with synchronous, active-high reset. Default is one bit, one stage.
- Generic storage/retiming primitive used wherever a single registered signal or short delay line with a known reset value is needed.
- Optional pipeline depth allows the same block to act as an N-stage delay line.

---
 rtl/dff_r.sv | 42 ++++
 tb/tb_dff_r.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_r.sv
// Parameterizable D-type register / delay line with a synchronous, active-high reset.
// q is the last stage of a STAGES-deep shift chain; every stage reloads RESET_VALUE on reset.
module dff_r #(
  parameter int              WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              STAGES      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // STAGES must be at least 1; a zero-length chain would give q a combinational path from d.
  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  // NOTE: every element of stage_d is assigned on every pass, so no latch can be inferred.
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: non-blocking assignments let all stages sample their old neighbours on the same edge.
  // NOTE: every stage is reset, so a mid-stream reset flushes all in-flight data, not just q.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: tb/tb_dff_r.sv
// Self-checking bench for dff_r: single-bit DFF, 8-bit 3-stage pipe, and a randomized
// 16-bit 4-stage pipe compared against a windowed reference model.
module tb_dff_r;

  localparam logic [7:0]  RV3 = 8'hA5;
  localparam int          S4  = 4;
  localparam logic [15:0] RV4 = 16'hBEEF;
  localparam int          NRAND = 300;

  logic        clk = 1'b0;
  logic        r1, r3, r4;
  logic        d1;
  logic [7:0]  d3;
  logic [15:0] d4;
  logic        q1;
  logic [7:0]  q3;
  logic [15:0] q4;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dff_r u_dut1 (.clk(clk), .reset(r1), .d(d1), .q(q1));

  dff_r #(.WIDTH(8), .RESET_VALUE(RV3), .STAGES(3))
    u_dut3 (.clk(clk), .reset(r3), .d(d3), .q(q3));

  dff_r #(.WIDTH(16), .RESET_VALUE(RV4), .STAGES(S4))
    u_dut4 (.clk(clk), .reset(r4), .d(d4), .q(q4));

  // Reset held with d = 1 for two edges: q is 0 after each.
  task automatic test_reset();
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      tests_run++;
      if (q1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold edge%0d: q=%b expected 0", e, q1);
      end
    end
  endtask

  // Release reset 2 ns after an edge and follow d = 1, 0, 1.
  task automatic test_capture();
    logic pattern [3];
    pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b1;
    #1;
    r1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d1 = pattern[i];
      @(posedge clk); #1;
      tests_run++;
      if (q1 !== pattern[i]) begin
        tests_failed++;
        $display("FAIL capture step%0d: q=%b expected %b", i, q1, pattern[i]);
      end
      #1;
    end
  endtask

  // Reset raised between edges must not touch q until the next edge.
  task automatic test_sync_reset();
    #2;
    r1 = 1'b1;
    d1 = 1'b1;
    #1;
    tests_run++;
    if (q1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL sync_reset_before_edge: q=%b expected 1", q1);
    end
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      tests_run++;
      if (q1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL sync_reset_after_edge%0d: q=%b expected 0", e, q1);
      end
    end
    // Drop reset mid-cycle: q must hold the reset value until the edge.
    #2;
    r1 = 1'b0;
    d1 = 1'b1;
    #1;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL sync_release_before_edge: q=%b expected 0", q1);
    end
    @(posedge clk); #1;
    tests_run++;
    if (q1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL sync_release_after_edge: q=%b expected 1", q1);
    end
  endtask

  // A 0->1->0 pulse on d wholly between edges is invisible.
  task automatic test_glitch();
    d1 = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_setup: q=%b expected 0", q1);
    end
    #2; d1 = 1'b1;
    #2; d1 = 1'b0;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_between_edges: q=%b expected 0", q1);
    end
    @(posedge clk); #1;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_after_edge: q=%b expected 0", q1);
    end
  endtask

  // 8-bit, 3-stage pipe: reset value, latency, ordering, mid-stream flush.
  task automatic test_pipeline();
    logic [7:0] exp_q [5];
    exp_q[0] = RV3; exp_q[1] = RV3; exp_q[2] = 8'h01; exp_q[3] = 8'h02; exp_q[4] = 8'h03;
    @(negedge clk);
    r3 = 1'b1;
    d3 = 8'h5A;
    @(posedge clk); #1;
    tests_run++;
    if (q3 !== RV3) begin
      tests_failed++;
      $display("FAIL pipe_reset: q=%h expected %h", q3, RV3);
    end
    @(negedge clk);
    r3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d3 = 8'(i + 1);
      @(posedge clk); #1;
      tests_run++;
      if (q3 !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL pipe_latency edge%0d: q=%h expected %h", i + 1, q3, exp_q[i]);
      end
      @(negedge clk);
    end
    // Stages now hold 5,4,3; one reset edge must discard all of them.
    r3 = 1'b1;
    d3 = 8'hFF;
    @(posedge clk); #1;
    tests_run++;
    if (q3 !== RV3) begin
      tests_failed++;
      $display("FAIL pipe_midreset: q=%h expected %h", q3, RV3);
    end
    @(negedge clk);
    r3 = 1'b0;
    d3 = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (q3 !== ((i == 2) ? 8'h3C : RV3)) begin
        tests_failed++;
        $display("FAIL pipe_flush edge%0d: q=%h expected %h", i + 1, q3,
                 (i == 2) ? 8'h3C : RV3);
      end
      @(negedge clk);
      d3 = 8'h77;
    end
  endtask

  // Random d/reset on a 4-stage pipe. Model: q after edge k is RESET_VALUE if reset was
  // sampled at any of the last STAGES edges, otherwise the d sampled STAGES-1 edges earlier.
  task automatic test_random();
    logic [15:0] hist_d [NRAND];
    logic        hist_r [NRAND];
    logic [15:0] expq;
    int          bad;
    bad = 0;
    for (int k = 0; k < NRAND; k++) begin
      @(negedge clk);
      hist_d[k] = 16'($urandom);
      hist_r[k] = (k == 0) || ($urandom_range(0, 11) == 0);
      d4 = hist_d[k];
      r4 = hist_r[k];
      @(posedge clk); #1;
      expq = (k >= S4 - 1) ? hist_d[k - S4 + 1] : RV4;
      for (int j = k - S4 + 1; j <= k; j++) begin
        if (j >= 0 && hist_r[j]) expq = RV4;
      end
      tests_run++;
      if (q4 !== expq) begin
        tests_failed++;
        bad++;
        if (bad <= 10)
          $display("FAIL random edge%0d: q=%h expected %h", k, q4, expq);
      end
    end
  endtask

  initial begin
    r1 = 1'b1; d1 = 1'b1;
    r3 = 1'b1; d3 = 8'h00;
    r4 = 1'b1; d4 = 16'h0000;
    test_reset();
    test_capture();
    test_sync_reset();
    test_glitch();
    test_pipeline();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
